modexp_ctrl: RTL and testbench

//  Square-and-multiply sequencer: computes result = base^exp mod P, P = 2^24-3.

---
 rtl/modexp_ctrl_if.sv | 26 ++
 rtl/modexp_ctrl.sv | 117 +++++++++++
 tb/tb_modexp_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_ctrl_if.sv
// Host and modmul connection bundle for modexp_ctrl: start/busy/done handshake,
// operands and result, plus the a/b/product link to the combinational modmul.
interface modexp_ctrl_if #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned EXP_WIDTH = 24
);
  logic                 start;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exp;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic [WIDTH-1:0]     mm_a;
  logic [WIDTH-1:0]     mm_b;
  logic [WIDTH-1:0]     mm_m;

  modport slave (
    input  start, base, exp, mm_m,
    output busy, done, result, mm_a, mm_b
  );

  modport master (
    output start, base, exp, mm_m,
    input  busy, done, result, mm_a, mm_b
  );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod (2^24-3)
// through an external combinational modmul. Optional build macro: MODEXP_EARLY_EXIT_EN.
module modexp_ctrl #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned EXP_WIDTH = 24
) (
  input  logic         clk,
  input  logic         reset,
  modexp_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     mm_a, mm_b;

`ifdef MODEXP_EARLY_EXIT_EN
  logic [IDX_W-1:0] msb_idx;

  // Index of the highest set exponent bit; leading zeros would only square 1.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (bus.exp[i]) msb_idx = IDX_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      // Capture on the DONE entry edge so result is valid alongside done.
      if (state_d == DONE) result_q <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    idx_d   = idx_q;
    mm_a    = '0;
    mm_b    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base;
          exp_d   = bus.exp;
          acc_d   = WIDTH'(1);
`ifdef MODEXP_EARLY_EXIT_EN
          idx_d   = msb_idx;
          state_d = (bus.exp == '0) ? DONE : SQR;
`else
          idx_d   = IDX_W'(EXP_WIDTH - 1);
          state_d = SQR;
`endif
        end
      end
      SQR: begin
        mm_a  = acc_q;
        mm_b  = acc_q;
        acc_d = bus.mm_m;
        if (exp_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      MUL: begin
        mm_a  = acc_q;
        mm_b  = base_q;
        acc_d = bus.mm_m;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SQR;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mm_a   = mm_a;
  assign bus.mm_b   = mm_b;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: models modmul, scoreboards expected
// results/latencies per accepted start. Honours MODEXP_EARLY_EXIT_EN.
module tb_modexp_ctrl;

  localparam int unsigned W  = 24;
  localparam int unsigned EW = 24;
  localparam logic [47:0] P  = 48'hFFFFFD;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           t0;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  sb_t  sb_q[$];

  modexp_ctrl_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational modmul stand-in.
  assign bus.mm_m = W'((48'(bus.mm_a) * 48'(bus.mm_b)) % P);

  // Right-to-left reference exponentiation.
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [EW-1:0] e);
    longint unsigned r = 1;
    longint unsigned x = longint'(b) % longint'(P);
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * x) % longint'(P);
      x = (x * x) % longint'(P);
    end
    return W'(r);
  endfunction

  function automatic int ref_lat(input logic [EW-1:0] e);
    int pc = 0;
    int msb = 0;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) begin
        pc++;
        msb = i;
      end
    end
`ifdef MODEXP_EARLY_EXIT_EN
    if (e == '0) return 1;
    return msb + 1 + pc + 1;
`else
    return EW + pc + 1;
`endif
  endfunction

  // Called at a negedge in IDLE; returns just after the accepting posedge.
  task automatic issue(input logic [W-1:0] b, input logic [EW-1:0] e);
    sb_t ent;
    bus.start = 1'b1;
    bus.base  = b;
    bus.exp   = e;
    @(posedge clk);
    #1;
    ent.res = ref_pow(b, e);
    ent.lat = ref_lat(e);
    ent.t0  = cyc;
    sb_q.push_back(ent);
    bus.start = 1'b0;
    bus.base  = $urandom;
    bus.exp   = $urandom;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b expected 1", bus.busy);
    end
  endtask

  // Waits (bounded) for done, checks against the scoreboard head; ends at the negedge after DONE.
  task automatic wait_done(input string name);
    sb_t ent;
    int  n = 0;
    bit  seen = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) seen = 1;
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
      return;
    end
    ent = sb_q.pop_front();
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", name, n);
      return;
    end
    n_checks++;
    if (bus.result !== ent.res) begin
      n_fail++;
      $display("FAIL %s_result: got %h expected %h", name, bus.result, ent.res);
    end
    n_checks++;
    if (cyc - ent.t0 + 1 != ent.lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected %0d", name, cyc - ent.t0 + 1, ent.lat);
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy_in_done: got %b expected 1", name, bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== ent.res) begin
      n_fail++;
      $display("FAIL %s_after_done: got done=%b busy=%b result=%h expected done=0 busy=0 result=%h",
               name, bus.done, bus.busy, bus.result, ent.res);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] b, input logic [EW-1:0] e);
    issue(b, e);
    wait_done(name);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 ||
        bus.mm_a !== '0 || bus.mm_b !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h mm_a=%h mm_b=%h expected all zero",
               bus.busy, bus.done, bus.result, bus.mm_a, bus.mm_b);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_vectors();
    run_op("b2_e3",       24'd2,      24'd3);
    run_op("exp_zero",    24'h123456, 24'd0);
    run_op("base_zero",   24'd0,      24'd5);
    run_op("zero_zero",   24'd0,      24'd0);
    run_op("pm1_e2",      24'hFFFFFC, 24'd2);
    run_op("pm1_e3",      24'hFFFFFC, 24'd3);
    run_op("fermat",      24'd3,      24'hFFFFFC);
    run_op("base_ge_p",   24'hFFFFFF, 24'd7);
    run_op("exp_all_one", 24'h00BEEF, 24'hFFFFFF);
    run_op("exp_msb",     24'd5,      24'h800000);
  endtask

  task automatic test_ignore_start();
    issue(24'd2, 24'd3);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.base  = 24'd5;
    bus.exp   = 24'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_start");
    repeat (60) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_start_extra: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    issue(24'd3, 24'hFFFFFC);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 ||
        bus.mm_a !== '0 || bus.mm_b !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b result=%h mm_a=%h expected zeros",
               bus.busy, bus.done, bus.result, bus.mm_a);
    end
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.result !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_no_done: got done=%b result=%h expected 0 0", bus.done, bus.result);
      end
    end
    run_op("after_reset", 24'd2, 24'd3);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", 24'd7,      24'd10);
    run_op("b2b_1", 24'h654321, 24'h000011);
    run_op("b2b_2", 24'd11,     24'd0);
    for (int i = 0; i < 4; i++) begin
      run_op("rand", W'($urandom), EW'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
